// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: RV32I load/store funct3 encodings
// and the stage FSM state type.
package mem_access_stage_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (size lives in funct3[1:0])
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering for the MEM stage: store byte enables and lane
// replication, load lane extraction with sign/zero extension, and the
// misaligned-access check. Purely combinational.
import mem_access_stage_pkg::*;

module mem_lane_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_ext_o,
  output logic        misaligned_o
);

  logic [31:0] load_shifted;

  // Move the addressed lane down to bit 0 before extension.
  assign load_shifted = load_word_i >> {addr_lo_i, 3'b000};

  // Store side: size comes from funct3[1:0]; the reserved size 2'b11 is
  // treated as a word so it is flagged unless word-aligned.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      F3_SB[1:0]: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_SH[1:0]: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

  // Load side: signed variants replicate the lane MSB, unsigned zero-fill.
  always_comb begin
    load_ext_o = load_word_i;
    case (funct3_i)
      F3_LB:   load_ext_o = {{24{load_shifted[7]}}, load_shifted[7:0]};
      F3_LH:   load_ext_o = {{16{load_shifted[15]}}, load_shifted[15:0]};
      F3_LBU:  load_ext_o = {24'h000000, load_shifted[7:0]};
      F3_LHU:  load_ext_o = {16'h0000, load_shifted[15:0]};
      F3_LW:   load_ext_o = load_word_i;
      default: load_ext_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage and MEM/WB boundary register. Issues RV32I loads and
// stores on the data-memory port and stalls upstream while an access is
// in flight.
//
// Data-memory handshake: dmem_req is the request valid and dmem_gnt its
// ready; a request transfers in the cycle both are high. The request is
// held with stable address/data until granted. Load data returns later as
// a single-cycle dmem_rvalid pulse, never in the grant cycle, and is only
// accepted in LOAD_WAIT.
import mem_access_stage_pkg::*;

module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [ADDR_WIDTH-1:0] mem_daddr,
  input  logic                  mem_mem_write,
  input  logic                  mem_mem_read,
  input  logic [2:0]            mem_funct3,
  input  logic [4:0]            mem_reg_dest,
  input  logic                  mem_reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] wb_result,
  output logic [4:0]            wb_reg_dest,
  output logic                  wb_reg_write,
  output logic                  wb_misaligned
);

  mem_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] wb_result_q;
  logic [4:0]            wb_reg_dest_q;
  logic                  wb_reg_write_q;
  logic                  wb_misaligned_q;

  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] lane_load_ext;
  logic                  lane_misaligned;

  logic                  mis;
  logic                  load_done;

  mem_lane_align u_lane_align (
    .funct3_i     (mem_funct3),
    .addr_lo_i    (mem_daddr[1:0]),
    .store_data_i (mem_write_data),
    .load_word_i  (dmem_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_ext_o   (lane_load_ext),
    .misaligned_o (lane_misaligned)
  );

  assign dmem_addr  = {mem_daddr[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata = lane_wdata;

  // FSM state register; reset abandons any outstanding load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory-port/stall outputs; reads win over writes.
  always_comb begin
    state_d   = state_q;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_be   = 4'b0000;
    stall     = 1'b0;
    mis       = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if ((mem_mem_read || mem_mem_write) && lane_misaligned) begin
          mis = 1'b1;
        end else if (mem_mem_read) begin
          dmem_req = 1'b1;
          stall    = 1'b1;
          if (dmem_gnt) state_d = LOAD_WAIT;
        end else if (mem_mem_write) begin
          dmem_req = 1'b1;
          dmem_we  = 1'b1;
          dmem_be  = lane_be;
          stall    = !dmem_gnt;
        end
      end
      LOAD_WAIT: begin
        stall = !dmem_rvalid;
        if (dmem_rvalid) begin
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB register: advance when not stalled, insert a bubble otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_result_q     <= '0;
      wb_reg_dest_q   <= 5'd0;
      wb_reg_write_q  <= 1'b0;
      wb_misaligned_q <= 1'b0;
    end else if (!stall) begin
      wb_result_q     <= load_done ? lane_load_ext : mem_alu_result;
      wb_reg_dest_q   <= mem_reg_dest;
      wb_reg_write_q  <= mem_reg_write && (mem_reg_dest != 5'd0) && !mis;
      wb_misaligned_q <= mis;
    end else begin
      wb_reg_write_q  <= 1'b0;
      wb_misaligned_q <= 1'b0;
    end
  end

  assign wb_result     = wb_result_q;
  assign wb_reg_dest   = wb_reg_dest_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage, directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM register outputs and performs RV32I loads and stores over a valid/grant/rvalid data-memory port, stalling the pipeline while an access is outstanding.
- Byte-lane alignment: store byte enables and load sign/zero extension.
- Registers the write-back result: it is the MEM/WB boundary register feeding the WB stage.

Parameters:
DATA_WIDTH, 32, data path width (only 32 supported)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mem_alu_result  in  DATA_WIDTH  ALU result from EX/MEM
mem_write_data  in  DATA_WIDTH  store data (unshifted, LSB-aligned)
mem_daddr  in  ADDR_WIDTH  byte address
mem_mem_write  in  1  store request
mem_mem_read  in  1  load request
mem_funct3  in  3  access size/sign (RV32I load/store encodings)
mem_reg_dest  in  5  destination register
mem_reg_write  in  1  instruction writes rd
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_WIDTH  word-aligned address (daddr with [1:0] = 0)
dmem_wdata  out  DATA_WIDTH  lane-shifted store data
dmem_be  out  4  byte enables
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  DATA_WIDTH  raw load word
stall  out  1  freeze IF..EX/MEM this cycle
wb_result  out  DATA_WIDTH  write-back value
wb_reg_dest  out  5  write-back rd
wb_reg_write  out  1  write-back enable
wb_misaligned  out  1  one-cycle misaligned-access flag

Behaviour:
- Reset (async, active-high): state IDLE; wb_result = 0, wb_reg_dest = 0, wb_reg_write = 0, wb_misaligned = 0.
- States: IDLE, LOAD_WAIT.
- Access classification (mem_mem_read has priority if both read and write are set):
  - Misaligned: half access with daddr[0] = 1, or word access with daddr[1:0] != 0.
  - A misaligned access never raises dmem_req.
  - At the edge: wb_misaligned <= 1, wb_reg_write <= 0, stall = 0.
- IDLE, no memory access:
  - dmem_req = 0, stall = 0.
  - At the edge: wb_result <= mem_alu_result.
- IDLE, aligned store:
  - dmem_req = 1, dmem_we = 1.
  - dmem_be: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << addr[1:0]; SW = 4'b1111.
  - dmem_wdata: store data replicated across lanes.
  - stall = !dmem_gnt.
  - On grant the store is complete: stall drops the same cycle and state stays IDLE.
- IDLE, aligned load:
  - dmem_req = 1, dmem_we = 0, dmem_be = 0, stall = 1.
  - On dmem_gnt: next state LOAD_WAIT.
- LOAD_WAIT:
  - dmem_req = 0, stall = !dmem_rvalid.
  - On dmem_rvalid: extract the lane selected by the captured daddr[1:0].
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Write wb_result, then return to IDLE.
  - Grant and rvalid in the same cycle is not legal: rvalid is at least 1 cycle after gnt.
- WB register update:
  - On every edge with stall = 0: wb_reg_dest <= mem_reg_dest; wb_reg_write <= mem_reg_write && (mem_reg_dest != 0) && !misaligned.
  - wb_misaligned is 0 unless the access is misaligned.
  - On edges with stall = 1: wb_reg_write <= 0 and wb_misaligned <= 0 (bubble into WB); wb_result holds.
- Inputs are held stable by the upstream stall, so no internal input capture is needed beyond state.
- dmem_rvalid in IDLE is ignored.
- Reset during LOAD_WAIT drops the outstanding load. The memory must be reset by the same rst.
- Latency: non-memory and store ops take 1 cycle (plus grant wait); loads take 1 + grant wait + response latency.

Decomposition:
- Shared package: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum {IDLE, LOAD_WAIT}.
- One combinational sub-module, mem_lane_align: takes funct3, addr[1:0], store data and raw load word; produces dmem_be, shifted wdata, extended load value and the misaligned flag.

Test Plan:
- ALU op, alu_result = 0x12345678, rd = 5, reg_write = 1 -> no dmem_req; next cycle wb_result = 0x12345678, wb_reg_dest = 5, wb_reg_write = 1.
- SB, daddr = 0x1003, data = 0xAB, gnt after 2 cycles -> dmem_be = 1000, dmem_wdata byte3 = 0xAB, dmem_addr = 0x1000, stall high 2 cycles, then low.
- LB, daddr = 0x2001, rdata = 0x0000_8000, gnt immediate, rvalid 3 cycles later -> wb_result = 0xFFFF_FF80, stall deasserts on the rvalid cycle.
- LHU, daddr = 0x2002, rdata = 0xBEEF_0000 -> wb_result = 0x0000_BEEF.
- LW, daddr = 0x2002 -> no dmem_req, wb_misaligned = 1 for 1 cycle, wb_reg_write = 0, stall = 0.
- Load granted, rst asserted in LOAD_WAIT -> state IDLE and all wb_* = 0 immediately; a later stray rvalid is ignored.
